// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 scan-code constants, decoder states and default key table
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_EXT,
        DEC_BRK,
        DEC_EXTBRK
    } dec_state_t;

    // Key table entries are {ext, code}
    localparam logic [8:0] KEY_SPACE = 9'h029;
    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_W     = 9'h01D;
    localparam logic [8:0] KEY_ENTER = 9'h05A;

    localparam logic [35:0] DEFAULT_KEY_CODES = {KEY_ENTER, KEY_W, KEY_UP, KEY_SPACE};

    // Bytes that never carry key meaning and abort any pending prefix
    function automatic logic is_flush_code(input logic [7:0] b);
        return (b == PS2_PAUSE) || (b == PS2_BAT) || (b == PS2_ACK) ||
               (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 pin synchroniser, tick divider and 11-bit frame deserialiser
module ps2_frame_rx #(
    parameter int CLK_DIV = 250,
    parameter int TIMEOUT = 4000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       PS2_KBCLK,
    input  logic       PS2_KBDAT,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);
    import ps2_pkg::*;

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    logic [1:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic             clk_prev;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [9:0]       shift_q;
    logic [TO_W-1:0]  to_cnt;

    logic        tick;
    logic        clk_fall;
    logic [10:0] frame;
    logic        frame_ok;

    assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign clk_fall = clk_prev & ~clk_sync[1];
    // Completed frame as it will look once the current bit lands: [0]=start, [10]=stop
    assign frame    = {dat_sync[1], shift_q};
    assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_prev   <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], PS2_KBCLK};
            dat_sync   <= {dat_sync[0], PS2_KBDAT};
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            div_cnt    <= tick ? '0 : div_cnt + 1'b1;

            if (tick) begin
                clk_prev <= clk_sync[1];
                if (clk_fall) begin
                    to_cnt <= '0;
                    if (bit_cnt == 4'd10) begin
                        bit_cnt <= '0;
                        if (frame_ok) begin
                            byte_valid <= 1'b1;
                            byte_data  <= frame[8:1];
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        shift_q <= {dat_sync[1], shift_q[9:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end else if (bit_cnt != 4'd0) begin
                    // Stalled partial frame: drop it so the next start bit realigns
                    if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// rtl/ps2_key_tracker.sv - PS/2 make/break decoder with multi-key held-state and press-edge tracking
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int                       CLK_DIV   = 250,
    parameter int                       TIMEOUT   = 4000,
    parameter int                       NUM_KEYS  = 4,
    parameter logic [9*NUM_KEYS-1:0]    KEY_CODES = (9*NUM_KEYS)'(DEFAULT_KEY_CODES)
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                PS2_KBCLK,
    input  logic                PS2_KBDAT,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] key_press,
    output logic                byte_valid,
    output logic [7:0]          byte_data,
    output logic                frame_err
);

    dec_state_t          state_q;
    dec_state_t          state_d;
    logic                do_make;
    logic                do_brk;
    logic                code_ext;
    logic [NUM_KEYS-1:0] hit;

    ps2_frame_rx #(
        .CLK_DIV (CLK_DIV),
        .TIMEOUT (TIMEOUT)
    ) u_frame_rx (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .PS2_KBCLK  (PS2_KBCLK),
        .PS2_KBDAT  (PS2_KBDAT),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= DEC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        do_make  = 1'b0;
        do_brk   = 1'b0;
        code_ext = 1'b0;
        if (frame_err) begin
            state_d = DEC_IDLE;
        end else if (byte_valid) begin
            if (is_flush_code(byte_data)) begin
                state_d = DEC_IDLE;
            end else begin
                unique case (state_q)
                    DEC_IDLE: begin
                        if (byte_data == PS2_EXT) begin
                            state_d = DEC_EXT;
                        end else if (byte_data == PS2_BRK) begin
                            state_d = DEC_BRK;
                        end else begin
                            do_make = 1'b1;
                        end
                    end
                    DEC_EXT: begin
                        if (byte_data == PS2_BRK) begin
                            state_d = DEC_EXTBRK;
                        end else if (byte_data == PS2_EXT) begin
                            state_d = DEC_EXT;
                        end else begin
                            do_make  = 1'b1;
                            code_ext = 1'b1;
                            state_d  = DEC_IDLE;
                        end
                    end
                    DEC_BRK: begin
                        do_brk  = 1'b1;
                        state_d = DEC_IDLE;
                    end
                    DEC_EXTBRK: begin
                        do_brk   = 1'b1;
                        code_ext = 1'b1;
                        state_d  = DEC_IDLE;
                    end
                endcase
            end
        end
    end

    // Every table slot matching {ext, code} is hit, so duplicate entries move together
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            hit[i] = (KEY_CODES[9*i +: 9] == {code_ext, byte_data});
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            key_down  <= '0;
            key_press <= '0;
        end else begin
            key_press <= '0;
            if (do_make) begin
                key_down  <= key_down | hit;
                key_press <= hit & ~key_down;
            end else if (do_brk) begin
                key_down <= key_down & ~hit;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb/tb_ps2_key_tracker.sv - scoreboard bench for ps2_key_tracker with a PS/2 keyboard model
module tb_ps2_key_tracker;

    localparam int CLK_DIV = 4;
    localparam int TIMEOUT = 50;
    localparam int HALF    = 24;

    logic       clk;
    logic       resetn;
    logic       kbclk;
    logic       kbdat;
    logic [3:0] key_down;
    logic [3:0] key_press;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    ps2_key_tracker #(
        .CLK_DIV  (CLK_DIV),
        .TIMEOUT  (TIMEOUT),
        .NUM_KEYS (4)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .PS2_KBCLK  (kbclk),
        .PS2_KBDAT  (kbdat),
        .key_down   (key_down),
        .key_press  (key_press),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] data;
        logic [3:0] down;
        logic [3:0] press;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: set of held keys plus pending-prefix flags
    logic [8:0] ktab [4] = '{9'h029, 9'h175, 9'h01D, 9'h05A};
    logic [3:0] m_down = '0;
    bit         m_ext  = 0;
    bit         m_brk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input bit bad);
        exp_t       e;
        logic [3:0] press = '0;
        if (bad) begin
            m_ext = 0;
            m_brk = 0;
            e.err = 1;
            e.data = 8'h00;
        end else begin
            e.err  = 0;
            e.data = b;
            if (b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF}) begin
                m_ext = 0;
                m_brk = 0;
            end else if (m_brk) begin
                for (int k = 0; k < 4; k++)
                    if (ktab[k] == {m_ext, b}) m_down[k] = 1'b0;
                m_ext = 0;
                m_brk = 0;
            end else if (b == 8'hE0) begin
                m_ext = 1;
            end else if (b == 8'hF0) begin
                m_brk = 1;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (ktab[k] == {m_ext, b}) begin
                        if (!m_down[k]) press[k] = 1'b1;
                        m_down[k] = 1'b1;
                    end
                end
                m_ext = 0;
            end
        end
        e.down  = m_down;
        e.press = press;
        sb.push_back(e);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            kbdat = f[i];
            repeat (HALF) @(posedge clk);
            #1 kbclk = 1'b0;
            repeat (HALF) @(posedge clk);
            #1 kbclk = 1'b1;
        end
        kbdat = 1'b1;
        repeat (3 * HALF) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        model_byte(b, bad);
        send_bits(mk_frame(b, bad), 11);
    endtask

    // Monitor: pops one expectation per DUT frame output
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && (byte_valid || frame_err)) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got valid=%0b err=%0b data=%0h expected none",
                             byte_valid, frame_err, byte_data);
                end else begin
                    e = sb.pop_front();
                    chk("frame_err", {31'd0, frame_err}, {31'd0, e.err});
                    chk("byte_valid", {31'd0, byte_valid}, {31'd0, ~e.err});
                    if (!e.err) chk("byte_data", {24'd0, byte_data}, {24'd0, e.data});
                    @(negedge clk);
                    chk("key_down", {28'd0, key_down}, {28'd0, e.down});
                    chk("key_press", {28'd0, key_press}, {28'd0, e.press});
                    @(negedge clk);
                    chk("key_press_clear", {28'd0, key_press}, 32'd0);
                end
            end
        end
    end

    initial begin
        logic [7:0] pool [8] = '{8'h29, 8'h75, 8'h1D, 8'h5A, 8'hE0, 8'hF0, 8'hE1, 8'hAA};
        logic [7:0] b;
        resetn = 1'b0;
        kbclk  = 1'b1;
        kbdat  = 1'b1;
        repeat (5) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("reset_key_down", {28'd0, key_down}, 32'd0);
        chk("reset_key_press", {28'd0, key_press}, 32'd0);
        chk("reset_byte_valid", {31'd0, byte_valid}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset_byte_data", {24'd0, byte_data}, 32'd0);

        // Space make, typematic repeats, then break
        send_byte(8'h29, 0);
        send_byte(8'h29, 0);
        send_byte(8'h29, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h29, 0);

        // Extended up arrow, W, extended break, plain 75
        send_byte(8'hE0, 0);
        send_byte(8'h75, 0);
        send_byte(8'h1D, 0);
        send_byte(8'hE0, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h75, 0);
        send_byte(8'h75, 0);

        // Parity error, and a bad frame cancelling a pending E0
        send_byte(8'h29, 1);
        send_byte(8'h29, 0);
        send_byte(8'hE0, 0);
        send_byte(8'h29, 1);
        send_byte(8'hF0, 0);
        send_byte(8'h29, 0);

        // Partial frame abandoned past the timeout
        send_bits(mk_frame(8'h29, 0), 5);
        repeat (8 * TIMEOUT * CLK_DIV / 4) @(posedge clk);
        send_byte(8'h5A, 0);

        // Reset mid-frame while keys are held
        send_byte(8'h29, 0);
        send_bits(mk_frame(8'h1D, 0), 4);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        m_down = '0;
        m_ext  = 0;
        m_brk  = 0;
        @(negedge clk);
        chk("midreset_key_down", {28'd0, key_down}, 32'd0);
        chk("midreset_key_press", {28'd0, key_press}, 32'd0);
        chk("midreset_byte_data", {24'd0, byte_data}, 32'd0);
        chk("midreset_byte_valid", {31'd0, byte_valid}, 32'd0);
        send_byte(8'h29, 0);

        // Randomised traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) b = 8'($urandom_range(0, 255));
            else b = pool[$urandom_range(0, 7)];
            send_byte(b, $urandom_range(0, 7) == 0);
        end

        for (int i = 0; i < 3000 && sb.size() > 0; i++) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
